bitlogic_stream: RTL and testbench
==================================

# bitlogic_stream

Parametrised, pipelined successor to the team's single-bit combinational AND cell. It applies a selectable bitwise operation (AND / OR / XOR / ANDN) to WIDTH-bit operand pairs, either per beat or folded across a multi-beat packet. Operands and results move over valid/ready handshakes with a single registered output stage. The block sits between an operand source and a result consumer in the logic-test datapath.

## Interface
- WIDTH, 8, operand and result width in bits (>= 1)
- CNT_W, 4, width of the beat counter (>= 1)

- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  operand beat offered
- in_ready  output  1  block accepts a beat this cycle
- in_a  input  WIDTH  operand a
- in_b  input  WIDTH  operand b
- in_op  input  2  0 AND, 1 OR, 2 XOR, 3 ANDN (a & ~b)
- in_acc  input  1  1 = accumulate mode; sampled on the first beat of a packet only
- in_last  input  1  final beat of a packet; ignored when in_acc = 0 on the first beat
- out_valid  output  1  result held
- out_ready  input  1  consumer takes the result
- out_c  output  WIDTH  result
- out_count  output  CNT_W  beats folded into out_c; saturates at 2^CNT_W - 1

## Operation
- Beat accepted when in_valid && in_ready. Beat value v = a OP b, where OP is the packet's latched op.
- States:
  - IDLE: no packet open.
  - ACC: packet open; accumulator and count live.
  - FULL: result in output register.
- IDLE, accepted beat:
  - Latch op and acc mode.
  - If acc = 0 or in_last = 1: out_c <= v, out_count <= 1, go to FULL.
  - Else: acc <= v, count <= 1, go to ACC.
- ACC, accepted beat:
  - acc <= acc F v, where F is AND for op 0 and 3, OR for op 1, XOR for op 2.
  - count increments and saturates.
  - in_op and in_acc are ignored.
  - If in_last = 1: load the folded value and count into the output, go to FULL.
- FULL:
  - out_valid = 1; out_c and out_count hold stable until out_ready.
  - On out_ready, return to IDLE.
  - On out_ready with a same-cycle accepted beat, follow the IDLE/ACC rules above for that beat, so back-to-back throughput is one result per cycle.
- in_ready = !out_valid || out_ready, in every state.
- Reset values: out_valid 0, out_c 0, out_count 0, accumulator 0, count 0, state IDLE. in_ready is 1 one cycle after reset release.
- Reset asserted mid-packet discards the partial accumulator. No result is emitted for that packet.

## Timing
- Latency: result valid on the cycle after the last (or single) beat is accepted. out_c is registered; there is no combinational path from in_a/in_b to out_c.
- in_ready depends combinationally on out_ready only.
- Throughput: one beat per cycle absent backpressure.
- Held output: out_c and out_count do not change while out_valid && !out_ready.
- Count saturation: the count wraps never; a 20-beat packet with CNT_W = 4 reports 15.

## Structure
- Shared package `bitlogic_pkg` holds:
  - op enum: OP_AND = 2'd0, OP_OR = 2'd1, OP_XOR = 2'd2, OP_ANDN = 2'd3.
  - state enum: IDLE, ACC, FULL.
  - function `beat_op(op, a, b)`.
  - function `fold_op(op, x, y)`.
- One sub-module, `bitlogic_core`: purely combinational v / fold computation, parametrised on WIDTH. The top module owns the FSM, counter and output register.

## Test plan
- Single beats, WIDTH = 8, no backpressure:
  - a = 8'hF0, b = 8'h3C over ops 0..3 -> out_c = 8'h30, 8'hFC, 8'hCC, 8'hC0 on consecutive cycles.
  - out_count = 1 on each.
- Accumulate XOR packet of three beats, (a, b) = (8'h01, 0), (8'h02, 0), (8'h04, 0), last on beat 3 -> one result, out_c = 8'h07, out_count = 3.
  - in_op changed to AND on beat 2 has no effect.
- Backpressure: out_ready = 0 for 4 cycles after a result.
  - in_ready = 0, out_c stable.
  - Next beat is accepted the cycle out_ready rises, and its result appears the following cycle.
- Saturation, CNT_W = 4: 20-beat AND packet of all 8'hFF pairs -> out_c = 8'hFF, out_count = 15.
- Reset mid-packet: rst_n pulsed low after 2 of 3 beats.
  - All outputs 0 asynchronously.
  - A following single OR beat 8'h0A | 8'h50 yields 8'h5A with out_count = 1.
- Randomised 1000 beats with random in_last and out_ready against a scoreboard model -> zero mismatches, no dropped or duplicated results.

Source files
------------

// File: rtl/bitlogic_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bitlogic_pkg : shared op/state encodings and per-bit op helpers      |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
package bitlogic_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'd0,
    OP_OR   = 2'd1,
    OP_XOR  = 2'd2,
    OP_ANDN = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    FULL = 2'd2
  } state_e;

  function automatic logic beat_op(input op_e op, input logic a, input logic b);
    case (op)
      OP_AND:  beat_op = a & b;
      OP_OR:   beat_op = a | b;
      OP_XOR:  beat_op = a ^ b;
      default: beat_op = a & ~b;
    endcase
  endfunction

  // ANDN folds with AND so a packet reports bits clear in every b
  function automatic logic fold_op(input op_e op, input logic x, input logic y);
    case (op)
      OP_OR:   fold_op = x | y;
      OP_XOR:  fold_op = x ^ y;
      default: fold_op = x & y;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/bitlogic_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bitlogic_core : combinational beat value and accumulator fold        |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
module bitlogic_core
  import bitlogic_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] beat,
  output logic [WIDTH-1:0] fold
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign beat[i] = beat_op(op, a[i], b[i]);
    assign fold[i] = fold_op(op, acc[i], beat[i]);
  end

endmodule
`default_nettype wire

// File: rtl/bitlogic_stream.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bitlogic_stream : handshaked bitwise op, per beat or folded/packet   |
// | Revision        : 1.0                                                |
// +----------------------------------------------------------------------+
module bitlogic_stream
  import bitlogic_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  input  logic             in_acc,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_c,
  output logic [CNT_W-1:0] out_count
);

  localparam logic [CNT_W-1:0] c_count_max = '1;
  localparam logic [CNT_W-1:0] c_count_one = CNT_W'(1);

  state_e           r_state;
  op_e              r_op;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_count;
  logic             r_ready_en;

  op_e              w_op;
  logic [WIDTH-1:0] w_beat;
  logic [WIDTH-1:0] w_fold;
  logic [CNT_W-1:0] w_count_inc;
  logic             w_accept;

  // Inside an open packet the latched op wins over whatever is on in_op
  assign w_op        = (r_state == ACC) ? r_op : op_e'(in_op);
  assign w_count_inc = (r_count == c_count_max) ? r_count : r_count + 1'b1;
  assign in_ready    = r_ready_en && (!out_valid || out_ready);
  assign w_accept    = in_valid && in_ready;

  bitlogic_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .op   (w_op),
    .a    (in_a),
    .b    (in_b),
    .acc  (r_acc),
    .beat (w_beat),
    .fold (w_fold)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_op       <= OP_AND;
      r_acc      <= '0;
      r_count    <= '0;
      r_ready_en <= 1'b0;
      out_valid  <= 1'b0;
      out_c      <= '0;
      out_count  <= '0;
    end else begin
      r_ready_en <= 1'b1;
      case (r_state)
        ACC: begin
          if (w_accept) begin
            if (in_last) begin
              out_c     <= w_fold;
              out_count <= w_count_inc;
              out_valid <= 1'b1;
              r_state   <= FULL;
            end else begin
              r_acc   <= w_fold;
              r_count <= w_count_inc;
            end
          end
        end
        default: begin
          // FULL drains first; a same-cycle beat then starts as from IDLE
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            r_state   <= IDLE;
          end
          if (w_accept) begin
            r_op <= op_e'(in_op);
            if (!in_acc || in_last) begin
              out_c     <= w_beat;
              out_count <= c_count_one;
              out_valid <= 1'b1;
              r_state   <= FULL;
            end else begin
              r_acc   <= w_beat;
              r_count <= c_count_one;
              r_state <= ACC;
            end
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bitlogic_stream.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_bitlogic_stream : directed and scoreboarded bench for the stream  |
// | Revision           : 1.0                                             |
// +----------------------------------------------------------------------+
module tb_bitlogic_stream;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [1:0]       in_op;
  logic             in_acc;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_c;
  logic [CNT_W-1:0] out_count;

  typedef struct packed {
    logic [7:0] c;
    logic [3:0] n;
  } res_t;

  res_t q_exp[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   mon_en   = 1'b0;
  bit   rnd_bp   = 1'b0;
  bit   sent;

  always #5 clk = ~clk;

  bitlogic_stream #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .in_acc    (in_acc),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_c     (out_c),
    .out_count (out_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_out(input string tag, input logic [7:0] c, input logic [3:0] n);
    chk({tag, "_valid"}, 32'(out_valid), 32'h1);
    chk({tag, "_c"}, 32'(out_c), 32'(c));
    chk({tag, "_cnt"}, 32'(out_count), 32'(n));
  endtask

  function automatic logic [7:0] f_beat(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return a & ~b;
    endcase
  endfunction

  function automatic logic [7:0] f_fold(input logic [1:0] op, input logic [7:0] x, input logic [7:0] y);
    case (op)
      2'd1:    return x | y;
      2'd2:    return x ^ y;
      default: return x & y;
    endcase
  endfunction

  // Mid-cycle sample: a result seen here with out_ready high is taken at the next edge
  task automatic half();
    res_t r;
    @(negedge clk);
    if (mon_en && out_valid && out_ready) begin
      if (q_exp.size() == 0) begin
        chk("rnd_dup", 32'(out_valid), 32'h0);
      end else begin
        r = q_exp.pop_front();
        chk("rnd_c", 32'(out_c), 32'(r.c));
        chk("rnd_cnt", 32'(out_count), 32'(r.n));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_bp) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                      input logic acc, input logic last);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_op    = op;
    in_acc   = acc;
    in_last  = last;
    sent     = 1'b0;
    for (int k = 0; k < 50 && !sent; k++) begin
      half();
      sent = in_ready;
      tick();
    end
    if (!sent) chk("send_timeout", 32'h0, 32'h1);
  endtask

  initial begin
    logic [7:0] c_single [4];
    logic [7:0] ra, rb, v, m_acc;
    logic [1:0] rop, m_op;
    logic [3:0] m_cnt;
    logic       racc, rlast;
    bit         m_open;

    c_single = '{8'h30, 8'hFC, 8'hCC, 8'hC0};
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0;
    in_acc = 1'b0; in_last = 1'b0; out_ready = 1'b1;

    #12;
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_c", 32'(out_c), 32'h0);
    chk("rst_cnt", 32'(out_count), 32'h0);
    chk("rst_ready", 32'(in_ready), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    chk("ready_after_rst", 32'(in_ready), 32'h1);

    // Single beats, one result per cycle
    for (int i = 0; i < 4; i++) begin
      send(8'hF0, 8'h3C, 2'(i), 1'b0, 1'b0);
      chk_out("single", c_single[i], 4'd1);
    end

    // XOR packet; op and acc on later beats are ignored
    send(8'h01, 8'h00, 2'd2, 1'b1, 1'b0);
    chk("acc_open1", 32'(out_valid), 32'h0);
    send(8'h02, 8'h00, 2'd0, 1'b0, 1'b0);
    chk("acc_open2", 32'(out_valid), 32'h0);
    send(8'h04, 8'h00, 2'd0, 1'b1, 1'b1);
    chk_out("acc_xor", 8'h07, 4'd3);

    // Backpressure
    in_valid = 1'b0;
    half();
    tick();
    out_ready = 1'b0;
    send(8'hAA, 8'hFF, 2'd0, 1'b0, 1'b0);
    chk_out("bp_first", 8'hAA, 4'd1);
    in_a = 8'h55; in_b = 8'h0F; in_op = 2'd1; in_acc = 1'b0; in_last = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      half();
      chk("bp_ready", 32'(in_ready), 32'h0);
      chk("bp_hold", 32'(out_c), 32'hAA);
      tick();
    end
    out_ready = 1'b1;
    half();
    chk("bp_release", 32'(in_ready), 32'h1);
    tick();
    chk_out("bp_next", 8'h5F, 4'd1);

    // Count saturation over 20 beats
    for (int i = 0; i < 20; i++) begin
      send(8'hFF, 8'hFF, 2'd0, 1'b1, (i == 19));
      if (i == 18) chk("sat_open", 32'(out_valid), 32'h0);
    end
    chk_out("sat", 8'hFF, 4'd15);

    // Asynchronous reset with a packet open
    send(8'h01, 8'h02, 2'd1, 1'b1, 1'b0);
    send(8'h04, 8'h00, 2'd1, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_c", 32'(out_c), 32'h0);
    chk("mid_rst_cnt", 32'(out_count), 32'h0);
    chk("mid_rst_ready", 32'(in_ready), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    send(8'h0A, 8'h50, 2'd1, 1'b0, 1'b0);
    chk_out("post_rst_or", 8'h5A, 4'd1);
    send(8'h0F, 8'h33, 2'd3, 1'b1, 1'b1);
    chk_out("andn_first_last", 8'h0C, 4'd1);

    // Random traffic against the scoreboard
    in_valid = 1'b0;
    half();
    tick();
    mon_en = 1'b1;
    rnd_bp = 1'b1;
    m_open = 1'b0;
    m_acc  = '0;
    m_op   = '0;
    m_cnt  = '0;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        in_valid = 1'b0;
        half();
        tick();
      end
      ra    = 8'($urandom);
      rb    = 8'($urandom);
      rop   = 2'($urandom_range(0, 3));
      racc  = 1'($urandom_range(0, 1));
      rlast = ($urandom_range(0, 3) == 0) || (i == 999);
      send(ra, rb, rop, racc, rlast);
      if (!m_open) begin
        m_op = rop;
        v    = f_beat(rop, ra, rb);
        if (!racc || rlast) begin
          q_exp.push_back('{c: v, n: 4'd1});
        end else begin
          m_open = 1'b1;
          m_acc  = v;
          m_cnt  = 4'd1;
        end
      end else begin
        m_acc = f_fold(m_op, m_acc, f_beat(m_op, ra, rb));
        if (m_cnt != 4'd15) m_cnt = m_cnt + 4'd1;
        if (rlast) begin
          q_exp.push_back('{c: m_acc, n: m_cnt});
          m_open = 1'b0;
        end
      end
    end
    in_valid  = 1'b0;
    rnd_bp    = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 30 && q_exp.size() != 0; k++) begin
      half();
      tick();
    end
    chk("rnd_drain", 32'(q_exp.size()), 32'h0);
    chk("rnd_idle", 32'(out_valid), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
